// File: rtl/bsg_fpu_pkg.sv
// Shared FPU compare definitions: op encoding and canonical quiet NaN.
package bsg_fpu_pkg;

    typedef enum logic [2:0] {
        e_fpu_cmp_eq  = 3'd0,
        e_fpu_cmp_lt  = 3'd1,
        e_fpu_cmp_le  = 3'd2,
        e_fpu_cmp_min = 3'd3,
        e_fpu_cmp_max = 3'd4
    } bsg_fpu_cmp_op_e;

    // Canonical qNaN {0, exponent all ones, quiet bit, zeros}, right-aligned in 64 bits.
    function automatic logic [63:0] canonical_qnan(input int unsigned e_w, input int unsigned m_w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((i + 1 >= m_w) && (i < m_w + e_w)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bsg_fpu_cmp_pipe_if.sv
// Request/response bundle of the compare pipe.
interface bsg_fpu_cmp_pipe_if #(
    parameter int unsigned e_p = 8,
    parameter int unsigned m_p = 23
);
    localparam int unsigned w = 1 + e_p + m_p;

    logic         v_i;
    logic         ready_o;
    logic [w-1:0] a_i;
    logic [w-1:0] b_i;
    logic [2:0]   op_i;
    logic         v_o;
    logic         yumi_i;
    logic [w-1:0] z_o;
    logic         invalid_o;
    logic         flag_clear_i;
    logic         invalid_sticky_o;

    modport master (
        output v_i, a_i, b_i, op_i, yumi_i, flag_clear_i,
        input  ready_o, v_o, z_o, invalid_o, invalid_sticky_o
    );

    modport slave (
        input  v_i, a_i, b_i, op_i, yumi_i, flag_clear_i,
        output ready_o, v_o, z_o, invalid_o, invalid_sticky_o
    );

endinterface

// File: rtl/bsg_fpu_preprocess.sv
// Classifies one IEEE-754 operand: NaN, signalling NaN, zero, sign.
module bsg_fpu_preprocess #(
    parameter int unsigned e_p = 8,
    parameter int unsigned m_p = 23
) (
    input  logic [e_p+m_p:0] a_i,
    output logic             nan_o,
    output logic             snan_o,
    output logic             zero_o,
    output logic             sign_o
);
    logic [e_p-1:0] exp_f;
    logic [m_p-1:0] man_f;

    assign exp_f  = a_i[e_p+m_p-1:m_p];
    assign man_f  = a_i[m_p-1:0];
    assign nan_o  = (&exp_f) & (|man_f);
    assign snan_o = nan_o & ~man_f[m_p-1];
    assign zero_o = ~(|exp_f) & ~(|man_f);
    assign sign_o = a_i[e_p+m_p];

endmodule

// File: rtl/bsg_less_than.sv
// Unsigned magnitude compare.
module bsg_less_than #(
    parameter int unsigned width_p = 8
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               o
);
    assign o = (a_i < b_i);
endmodule

// File: rtl/bsg_fpu_cmp_pipe.sv
// Two-stage IEEE-754 compare/min/max pipe with valid/ready in, valid/yumi out.
module bsg_fpu_cmp_pipe
    import bsg_fpu_pkg::*;
#(
    parameter int unsigned e_p = 8,
    parameter int unsigned m_p = 23
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bsg_fpu_cmp_pipe_if.slave  io
);
    localparam int unsigned w = 1 + e_p + m_p;
    localparam logic [63:0]  qnan_full = canonical_qnan(e_p, m_p);
    localparam logic [w-1:0] qnan      = qnan_full[w-1:0];

    logic         s1_v, s2_v;
    logic [w-1:0] s1_a, s1_b;
    logic [2:0]   s1_op;
    logic [w-1:0] s2_z;
    logic         s2_inv;
    logic         sticky;

    logic s2_load, s1_load, accept;

    logic a_nan, a_snan, a_zero, a_sign;
    logic b_nan, b_snan, b_zero, b_sign;
    logic a_lt_b_mag, b_lt_a_mag;
    logic lt_ord, le_ord, any_nan, any_snan, both_zero;
    logic [w-1:0] cmp_z;
    logic         cmp_inv;

    assign s2_load    = ~s2_v | io.yumi_i;
    assign s1_load    = ~s1_v | s2_load;
    assign io.ready_o = ~reset_i & s1_load;
    assign accept     = io.v_i & io.ready_o;

    assign io.v_o             = s2_v;
    assign io.z_o             = s2_z;
    assign io.invalid_o       = s2_inv;
    assign io.invalid_sticky_o = sticky;

    bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) pre_a (
        .a_i(s1_a), .nan_o(a_nan), .snan_o(a_snan), .zero_o(a_zero), .sign_o(a_sign)
    );

    bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) pre_b (
        .a_i(s1_b), .nan_o(b_nan), .snan_o(b_snan), .zero_o(b_zero), .sign_o(b_sign)
    );

    bsg_less_than #(.width_p(w-1)) lt_ab (.a_i(s1_a[w-2:0]), .b_i(s1_b[w-2:0]), .o(a_lt_b_mag));
    bsg_less_than #(.width_p(w-1)) lt_ba (.a_i(s1_b[w-2:0]), .b_i(s1_a[w-2:0]), .o(b_lt_a_mag));

    // Compare/select logic between S1 and S2.
    always_comb begin
        cmp_z     = '0;
        cmp_inv   = 1'b0;
        any_nan   = a_nan | b_nan;
        any_snan  = a_snan | b_snan;
        both_zero = a_zero & b_zero;
        lt_ord    = (a_sign != b_sign) ? a_sign : (a_sign ? b_lt_a_mag : a_lt_b_mag);
        le_ord    = lt_ord | (s1_a == s1_b);
        case (bsg_fpu_cmp_op_e'(s1_op))
            e_fpu_cmp_eq: begin
                cmp_inv = any_snan;
                if (!any_nan) cmp_z = w'(both_zero | (s1_a == s1_b));
            end
            e_fpu_cmp_lt: begin
                cmp_inv = any_nan;
                if (!any_nan && !both_zero) cmp_z = w'(lt_ord);
            end
            e_fpu_cmp_le: begin
                cmp_inv = any_nan;
                if (!any_nan) cmp_z = w'(both_zero | le_ord);
            end
            e_fpu_cmp_min: begin
                cmp_inv = any_snan;
                if (a_nan && b_nan)  cmp_z = qnan;
                else if (a_nan)      cmp_z = s1_b;
                else if (b_nan)      cmp_z = s1_a;
                else if (both_zero)  cmp_z = {a_sign | b_sign, {(w-1){1'b0}}};
                else                 cmp_z = lt_ord ? s1_a : s1_b;
            end
            e_fpu_cmp_max: begin
                cmp_inv = any_snan;
                if (a_nan && b_nan)  cmp_z = qnan;
                else if (a_nan)      cmp_z = s1_b;
                else if (b_nan)      cmp_z = s1_a;
                else if (both_zero)  cmp_z = {a_sign & b_sign, {(w-1){1'b0}}};
                else                 cmp_z = lt_ord ? s1_b : s1_a;
            end
            default: begin
                cmp_z   = '0;
                cmp_inv = 1'b0;
            end
        endcase
    end

    // Pipeline stages and sticky invalid flag; set beats clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= '0;
            s2_v   <= 1'b0;
            s2_z   <= '0;
            s2_inv <= 1'b0;
            sticky <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_v <= accept;
                if (accept) begin
                    s1_a  <= io.a_i;
                    s1_b  <= io.b_i;
                    s1_op <= io.op_i;
                end
            end
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_z   <= cmp_z;
                    s2_inv <= cmp_inv;
                end
            end
            if (s2_v & io.yumi_i & s2_inv) sticky <= 1'b1;
            else if (io.flag_clear_i)      sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_fpu_cmp_pipe.sv
// Self-checking bench for bsg_fpu_cmp_pipe at half precision (e_p=5, m_p=10).
module tb_bsg_fpu_cmp_pipe;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic sticky_m = 1'b0;

    always #5 clk = ~clk;

    bsg_fpu_cmp_pipe_if #(.e_p(5), .m_p(10)) io ();

    bsg_fpu_cmp_pipe #(.e_p(5), .m_p(10)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (io)
    );

    task automatic check_z(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: IEEE compare rules using signed-integer ordering keys.
    function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        bit an, bn, as, bs, az, bz;
        int ka, kb;
        logic [15:0] z;
        logic inv;
        an = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
        bn = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
        as = an && !a[9];
        bs = bn && !b[9];
        az = (a[14:0] == 15'd0);
        bz = (b[14:0] == 15'd0);
        ka = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        kb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        z = 16'h0000;
        inv = 1'b0;
        case (op)
            3'd0: if (an || bn) inv = as || bs; else z[0] = (az && bz) || (a == b);
            3'd1: if (an || bn) inv = 1'b1; else z[0] = (ka < kb);
            3'd2: if (an || bn) inv = 1'b1; else z[0] = (ka <= kb);
            3'd3, 3'd4: begin
                inv = as || bs;
                if (an && bn)      z = 16'h7E00;
                else if (an)       z = b;
                else if (bn)       z = a;
                else if (az && bz) z = {(op == 3'd3) ? (a[15] | b[15]) : (a[15] & b[15]), 15'd0};
                else if (op == 3'd3) z = (ka < kb) ? a : b;
                else               z = (ka > kb) ? a : b;
            end
            default: ;
        endcase
        return {inv, z};
    endfunction

    function automatic logic [15:0] rand_operand();
        logic [15:0] specials [10];
        specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                     16'h7C01, 16'hFE12, 16'h3C00, 16'hBC00, 16'h0001};
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 9)];
        return 16'($urandom);
    endfunction

    // One isolated op: checks accept, 2-edge latency, result, sticky after consume.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input logic clr, input logic [15:0] ez, input logic einv, input string tag);
        @(negedge clk);
        io.a_i = a; io.b_i = b; io.op_i = op; io.v_i = 1'b1;
        #1 check_b({tag, "_ready"}, io.ready_o, 1'b1);
        @(negedge clk);
        io.v_i = 1'b0;
        check_b({tag, "_lat1"}, io.v_o, 1'b0);
        @(negedge clk);
        check_b({tag, "_v"}, io.v_o, 1'b1);
        check_z({tag, "_z"}, io.z_o, ez);
        check_b({tag, "_inv"}, io.invalid_o, einv);
        io.yumi_i = 1'b1;
        io.flag_clear_i = clr;
        @(negedge clk);
        io.yumi_i = 1'b0;
        io.flag_clear_i = 1'b0;
        sticky_m = einv ? 1'b1 : (clr ? 1'b0 : sticky_m);
        check_b({tag, "_sticky"}, io.invalid_sticky_o, sticky_m);
        check_b({tag, "_drained"}, io.v_o, 1'b0);
    endtask

    // Pipelined stream with a scoreboard; stalls either directed (cycles 3-6) or random.
    task automatic stream(input int n, input bit rand_yumi, input string tag);
        logic [15:0] qz[$];
        logic        qi[$];
        int issued = 0, got = 0, cyc = 0;
        bit held = 0, saw_stall = 0, pending = 0, stall;
        logic [15:0] pz, a, b;
        logic        pi;
        logic [2:0]  op;
        logic [16:0] r;
        while (got < n && cyc < n * 20 + 40) begin
            @(negedge clk);
            cyc++;
            check_b({tag, "_sticky"}, io.invalid_sticky_o, sticky_m);
            stall = rand_yumi ? ($urandom_range(0, 2) == 0) : (cyc >= 3 && cyc <= 6);
            io.yumi_i = io.v_o & ~stall;
            if (io.v_o) begin
                if (held) begin
                    check_z({tag, "_hold_z"}, io.z_o, pz);
                    check_b({tag, "_hold_inv"}, io.invalid_o, pi);
                end
                check_z({tag, "_order_z"}, io.z_o, (qz.size() != 0) ? qz[0] : 16'hxxxx);
                check_b({tag, "_order_inv"}, io.invalid_o, (qi.size() != 0) ? qi[0] : 1'bx);
                pz = io.z_o;
                pi = io.invalid_o;
                held = ~io.yumi_i;
                if (io.yumi_i) begin
                    if (qz.size() != 0) begin
                        void'(qz.pop_front());
                        void'(qi.pop_front());
                    end
                    if (io.invalid_o) sticky_m = 1'b1;
                    got++;
                end
            end else begin
                held = 0;
            end
            if (issued < n) begin
                if (!pending) begin
                    a = rand_operand(); b = rand_operand(); op = 3'($urandom_range(0, 7));
                    pending = 1;
                end
                io.a_i = a; io.b_i = b; io.op_i = op; io.v_i = 1'b1;
            end else begin
                io.v_i = 1'b0;
            end
            #1;
            if (io.v_i && io.ready_o) begin
                r = ref_model(a, b, op);
                qz.push_back(r[15:0]);
                qi.push_back(r[16]);
                issued++;
                pending = 0;
            end else if (io.v_i) begin
                saw_stall = 1;
            end
        end
        @(negedge clk);
        io.yumi_i = 1'b0;
        io.v_i = 1'b0;
        check_b({tag, "_all_received"}, (got == n), 1'b1);
        if (!rand_yumi) check_b({tag, "_ready_dropped"}, saw_stall, 1'b1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [2:0]  rop;
        logic [16:0] r;

        reset = 1'b1;
        io.v_i = 1'b0; io.a_i = '0; io.b_i = '0; io.op_i = '0;
        io.yumi_i = 1'b0; io.flag_clear_i = 1'b0;
        @(negedge clk);
        check_b("rst_ready", io.ready_o, 1'b0);
        @(negedge clk);
        check_b("rst_v", io.v_o, 1'b0);
        check_z("rst_z", io.z_o, 16'h0000);
        check_b("rst_inv", io.invalid_o, 1'b0);
        check_b("rst_sticky", io.invalid_sticky_o, 1'b0);
        reset = 1'b0;

        // LT basics
        run_op(16'h3C00, 16'h4000, 3'd1, 1'b0, 16'h0001, 1'b0, "lt_1_2");
        run_op(16'hC000, 16'hBC00, 3'd1, 1'b0, 16'h0001, 1'b0, "lt_m2_m1");
        run_op(16'h4000, 16'h3C00, 3'd1, 1'b0, 16'h0000, 1'b0, "lt_2_1");

        // Signed zeros
        run_op(16'h0000, 16'h8000, 3'd3, 1'b0, 16'h8000, 1'b0, "min_zero");
        run_op(16'h0000, 16'h8000, 3'd4, 1'b0, 16'h0000, 1'b0, "max_zero");
        run_op(16'h0000, 16'h8000, 3'd0, 1'b0, 16'h0001, 1'b0, "eq_zero");
        run_op(16'h0000, 16'h8000, 3'd2, 1'b0, 16'h0001, 1'b0, "le_zero");
        run_op(16'h0000, 16'h8000, 3'd1, 1'b0, 16'h0000, 1'b0, "lt_zero");

        // NaN handling
        run_op(16'h7C01, 16'h3C00, 3'd4, 1'b0, 16'h3C00, 1'b1, "max_snan");
        run_op(16'h7E00, 16'h7E05, 3'd3, 1'b0, 16'h7E00, 1'b0, "min_qnan2");
        run_op(16'h7E00, 16'h7E00, 3'd0, 1'b0, 16'h0000, 1'b0, "eq_qnan");
        run_op(16'h7E00, 16'h0000, 3'd2, 1'b0, 16'h0000, 1'b1, "le_qnan");

        // Backpressure: 6 back-to-back ops, consumer stalls cycles 3-6
        stream(6, 1'b0, "bp");

        // Sticky: clear coinciding with an invalid consume, then a lone clear
        run_op(16'h7E00, 16'h0000, 3'd1, 1'b1, 16'h0000, 1'b1, "set_wins");
        @(negedge clk);
        io.flag_clear_i = 1'b1;
        @(negedge clk);
        io.flag_clear_i = 1'b0;
        sticky_m = 1'b0;
        check_b("lone_clear", io.invalid_sticky_o, 1'b0);
        run_op(16'h1234, 16'h5678, 3'd6, 1'b0, 16'h0000, 1'b0, "reserved6");

        // Reset with two ops in flight
        run_op(16'h7C01, 16'h7C01, 3'd0, 1'b0, 16'h0000, 1'b1, "pre_rst_snan");
        @(negedge clk);
        io.a_i = 16'h3C00; io.b_i = 16'h4000; io.op_i = 3'd1; io.v_i = 1'b1;
        @(negedge clk);
        io.a_i = 16'h4000; io.b_i = 16'h3C00; io.op_i = 3'd4;
        @(negedge clk);
        io.v_i = 1'b0;
        check_b("inflight_v", io.v_o, 1'b1);
        reset = 1'b1;
        #1 check_b("midrst_ready", io.ready_o, 1'b0);
        @(negedge clk);
        check_b("midrst_v", io.v_o, 1'b0);
        check_z("midrst_z", io.z_o, 16'h0000);
        check_b("midrst_inv", io.invalid_o, 1'b0);
        check_b("midrst_sticky", io.invalid_sticky_o, 1'b0);
        check_b("midrst_ready2", io.ready_o, 1'b0);
        reset = 1'b0;
        sticky_m = 1'b0;
        @(negedge clk);
        check_b("post_rst_v", io.v_o, 1'b0);
        run_op(16'h3C00, 16'h4000, 3'd1, 1'b0, 16'h0001, 1'b0, "post_rst_lt");

        // Random isolated ops against the model
        for (int i = 0; i < 80; i++) begin
            ra = rand_operand(); rb = rand_operand(); rop = 3'($urandom_range(0, 7));
            r = ref_model(ra, rb, rop);
            run_op(ra, rb, rop, 1'b0, r[15:0], r[16], "rand_op");
        end

        // Random pipelined stream with random consumer stalls
        stream(300, 1'b1, "rand_stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
